// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD line-refresh scheduler: state encoding,
// HD44780-style command bytes and the default post-clear wait.
package lcd_pkg;

   localparam int unsigned NREQ   = 2;
   localparam int unsigned BUF_AW = 4;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WAIT_W = 16;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_CLRW,
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_DONE
   } state_t;

   localparam logic [BYTE_W-1:0] CMD_FUNC_SET = 8'h38;
   localparam logic [BYTE_W-1:0] CMD_DISP_ON  = 8'h0C;
   localparam logic [BYTE_W-1:0] CMD_ENTRY    = 8'h06;
   localparam logic [BYTE_W-1:0] CMD_CLEAR    = 8'h01;
   localparam logic [BYTE_W-1:0] CMD_LINE0    = 8'h80;
   localparam logic [BYTE_W-1:0] CMD_LINE1    = 8'hC0;

   localparam logic [WAIT_W-1:0] CLR_WAIT_DEF = 16'd2000;

   // Init command issued at each step of the power-up sequence.
   function automatic logic [BYTE_W-1:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    init_cmd = CMD_FUNC_SET;
         2'd1:    init_cmd = CMD_DISP_ON;
         2'd2:    init_cmd = CMD_ENTRY;
         default: init_cmd = CMD_CLEAR;
      endcase
   endfunction

endpackage

// File: rtl/lcd_sched_arb.sv
// Two-way requester arbiter. Round-robin by default; strict alert priority
// when LCD_SCHED_ALERT_PRIO_EN is defined.
module lcd_sched_arb
   import lcd_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] i_req,
   input  logic            i_take,
   output logic [NREQ-1:0] o_gnt_c
);

`ifdef LCD_SCHED_ALERT_PRIO_EN
   always_comb begin
      o_gnt_c = 2'b00;
      if (i_req[1])      o_gnt_c = 2'b10;
      else if (i_req[0]) o_gnt_c = 2'b01;
   end
`else
   logic r_last;

   // On a tie the requester that was not granted last wins.
   always_comb begin
      o_gnt_c = 2'b00;
      case (i_req)
         2'b01:   o_gnt_c = 2'b01;
         2'b10:   o_gnt_c = 2'b10;
         2'b11:   o_gnt_c = r_last ? 2'b01 : 2'b10;
         default: o_gnt_c = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)                      r_last <= 1'b0;
      else if (i_take && |o_gnt_c)  r_last <= o_gnt_c[1];
   end
`endif

endmodule

// File: rtl/lcd_sched.sv
// LCD scheduler: runs the init sequence, then streams 16-character line
// refreshes from two requesters to a byte-wide writer. Config macro:
// LCD_SCHED_ALERT_PRIO_EN (alert requester has strict priority).
module lcd_sched
   import lcd_pkg::*;
#(
   parameter logic [WAIT_W-1:0] CLR_WAIT = CLR_WAIT_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   req_line,
   output logic [BUF_AW-1:0] rd_addr,
   input  logic [BYTE_W-1:0] rd_data0,
   input  logic [BYTE_W-1:0] rd_data1,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic              wr_rs,
   output logic [BYTE_W-1:0] wr_data,
   output logic              init_done
);

   state_t              r_state,     w_state_nxt;
   logic [1:0]          r_init_idx,  w_init_idx_nxt;
   logic [WAIT_W-1:0]   r_cnt,       w_cnt_nxt;
   logic [BUF_AW-1:0]   r_bcnt,      w_bcnt_nxt;
   logic                r_line,      w_line_nxt;
   logic [NREQ-1:0]     r_gnt,       w_gnt_nxt;
   logic [NREQ-1:0]     r_done,      w_done_nxt;
   logic                r_wr_valid,  w_wr_valid_nxt;
   logic                r_wr_rs,     w_wr_rs_nxt;
   logic [BYTE_W-1:0]   r_wr_data,   w_wr_data_nxt;
   logic [BUF_AW-1:0]   r_rd_addr,   w_rd_addr_nxt;
   logic                r_init_done, w_init_done_nxt;

   logic                w_hs;
   logic                w_take;
   logic [NREQ-1:0]     w_arb_gnt;
   logic [BYTE_W-1:0]   w_rd_data;

   assign w_hs      = r_wr_valid && wr_ready;
   assign w_take    = (r_state == ST_IDLE);
   assign w_rd_data = r_gnt[1] ? rd_data1 : rd_data0;

   lcd_sched_arb u_arb (
      .clk     (clk),
      .rst     (rst),
      .i_req   (req),
      .i_take  (w_take),
      .o_gnt_c (w_arb_gnt)
   );

   // rd_addr runs one byte ahead of the byte on the bus so the registered
   // wr_data can be refilled on the same edge as the handshake.
   always_comb begin
      w_state_nxt     = r_state;
      w_init_idx_nxt  = r_init_idx;
      w_cnt_nxt       = r_cnt;
      w_bcnt_nxt      = r_bcnt;
      w_line_nxt      = r_line;
      w_gnt_nxt       = r_gnt;
      w_done_nxt      = '0;
      w_wr_valid_nxt  = r_wr_valid;
      w_wr_rs_nxt     = r_wr_rs;
      w_wr_data_nxt   = r_wr_data;
      w_rd_addr_nxt   = r_rd_addr;
      w_init_done_nxt = r_init_done;

      case (r_state)
         ST_INIT: begin
            w_wr_rs_nxt = 1'b0;
            if (w_hs) begin
               if (r_init_idx == 2'd3) begin
                  w_wr_valid_nxt = 1'b0;
                  w_cnt_nxt      = '0;
                  w_init_idx_nxt = 2'd0;
                  if (CLR_WAIT == '0) begin
                     w_state_nxt     = ST_IDLE;
                     w_init_done_nxt = 1'b1;
                  end else begin
                     w_state_nxt = ST_CLRW;
                  end
               end else begin
                  w_init_idx_nxt = r_init_idx + 2'd1;
                  w_wr_data_nxt  = init_cmd(r_init_idx + 2'd1);
                  w_wr_valid_nxt = 1'b1;
               end
            end else begin
               w_wr_data_nxt  = init_cmd(r_init_idx);
               w_wr_valid_nxt = 1'b1;
            end
         end

         ST_CLRW: begin
            if (r_cnt == CLR_WAIT - WAIT_W'(1)) begin
               w_cnt_nxt       = '0;
               w_state_nxt     = ST_IDLE;
               w_init_done_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + WAIT_W'(1);
            end
         end

         ST_IDLE: begin
            if (|w_arb_gnt) begin
               w_gnt_nxt      = w_arb_gnt;
               w_line_nxt     = |(req_line & w_arb_gnt);
               w_state_nxt    = ST_ADDR;
               w_wr_valid_nxt = 1'b1;
               w_wr_rs_nxt    = 1'b0;
               w_wr_data_nxt  = (|(req_line & w_arb_gnt)) ? CMD_LINE1 : CMD_LINE0;
               w_rd_addr_nxt  = '0;
               w_bcnt_nxt     = '0;
            end
         end

         ST_ADDR: begin
            if (w_hs) begin
               w_state_nxt    = ST_DATA;
               w_wr_valid_nxt = 1'b1;
               w_wr_rs_nxt    = 1'b1;
               w_wr_data_nxt  = w_rd_data;
               w_rd_addr_nxt  = r_rd_addr + BUF_AW'(1);
            end
         end

         ST_DATA: begin
            if (w_hs) begin
               if (r_bcnt == BUF_AW'(15)) begin
                  w_state_nxt    = ST_DONE;
                  w_wr_valid_nxt = 1'b0;
                  w_done_nxt     = r_gnt;
                  w_rd_addr_nxt  = '0;
                  w_bcnt_nxt     = '0;
               end else begin
                  w_bcnt_nxt    = r_bcnt + BUF_AW'(1);
                  w_wr_data_nxt = w_rd_data;
                  w_rd_addr_nxt = r_rd_addr + BUF_AW'(1);
               end
            end
         end

         ST_DONE: begin
            w_gnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
         end

         default: w_state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_INIT;
         r_init_idx  <= '0;
         r_cnt       <= '0;
         r_bcnt      <= '0;
         r_line      <= 1'b0;
         r_gnt       <= '0;
         r_done      <= '0;
         r_wr_valid  <= 1'b0;
         r_wr_rs     <= 1'b0;
         r_wr_data   <= '0;
         r_rd_addr   <= '0;
         r_init_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_init_idx  <= w_init_idx_nxt;
         r_cnt       <= w_cnt_nxt;
         r_bcnt      <= w_bcnt_nxt;
         r_line      <= w_line_nxt;
         r_gnt       <= w_gnt_nxt;
         r_done      <= w_done_nxt;
         r_wr_valid  <= w_wr_valid_nxt;
         r_wr_rs     <= w_wr_rs_nxt;
         r_wr_data   <= w_wr_data_nxt;
         r_rd_addr   <= w_rd_addr_nxt;
         r_init_done <= w_init_done_nxt;
      end
   end

   assign rd_addr   = r_rd_addr;
   assign gnt       = r_gnt;
   assign done      = r_done;
   assign wr_valid  = r_wr_valid;
   assign wr_rs     = r_wr_rs;
   assign wr_data   = r_wr_data;
   assign init_done = r_init_done;

endmodule

// File: tb/tb_lcd_sched.sv
// Scoreboard bench for lcd_sched: stimulus pushes expected bytes, grants and
// done pulses into queues; a negedge monitor pops and compares them.
module tb_lcd_sched;

   localparam logic [15:0] CW = 16'd20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] req = 2'b00;
   logic [1:0] req_line = 2'b00;
   logic [3:0] rd_addr;
   logic [7:0] rd_data0, rd_data1;
   logic [1:0] gnt, done;
   logic       wr_valid;
   logic       wr_ready = 1'b1;
   logic       wr_rs;
   logic [7:0] wr_data;
   logic       init_done;

   logic [7:0] buf0 [16];
   logic [7:0] buf1 [16];
   assign rd_data0 = buf0[rd_addr];
   assign rd_data1 = buf1[rd_addr];

   lcd_sched #(.CLR_WAIT(CW)) dut (
      .clk(clk), .rst(rst), .req(req), .req_line(req_line),
      .rd_addr(rd_addr), .rd_data0(rd_data0), .rd_data1(rd_data1),
      .gnt(gnt), .done(done), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_rs(wr_rs), .wr_data(wr_data), .init_done(init_done)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [8:0] exp_q  [$];
   logic [1:0] gnt_q  [$];
   logic [1:0] done_q [$];
   int  n_data_hs = 0;
   int  n_gnts    = 0;
   bit  rand_ready = 1'b0;
   int  model_last = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Ready driver: either tied high or randomly toggling.
   initial begin
      forever begin
         @(posedge clk);
         #1 wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: byte scoreboard, stall stability, grants, done pulses, clear wait.
   initial begin
      bit         stall = 0;
      logic [8:0] stall_word = '0;
      logic [1:0] prev_done = '0;
      logic [1:0] prev_gnt = '0;
      bit         counting = 0;
      int         clr_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall = 0; counting = 0; prev_done = '0; prev_gnt = '0;
         end else begin
            if (counting) begin
               if (init_done) begin
                  chk("clr_wait_cycles", clr_cnt, CW);
                  counting = 0;
               end else begin
                  clr_cnt++;
               end
            end
            if (stall) begin
               chk("stall_valid", wr_valid, 1);
               chk("stall_hold", {wr_rs, wr_data}, stall_word);
            end
            if (wr_valid && wr_ready) begin
               if (exp_q.size() == 0) flag("unexpected_byte");
               else chk("byte", {wr_rs, wr_data}, exp_q.pop_front());
               if (wr_rs) n_data_hs++;
               if (!init_done && !wr_rs && wr_data == 8'h01) begin
                  counting = 1; clr_cnt = 0;
               end
            end
            stall = wr_valid && !wr_ready;
            stall_word = {wr_rs, wr_data};
            if (gnt != 2'b00 && prev_gnt == 2'b00) begin
               n_gnts++;
               if (gnt_q.size() == 0) flag("unexpected_grant");
               else chk("grant", gnt, gnt_q.pop_front());
            end
            if (prev_done != 2'b00) chk("done_width", done, 0);
            if (done != 2'b00) begin
               if (done_q.size() == 0) flag("unexpected_done");
               else chk("done", done, done_q.pop_front());
            end
            prev_done = done;
            prev_gnt = gnt;
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      req = 2'b00;
      exp_q.delete(); gnt_q.delete(); done_q.delete();
      model_last = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_wr_valid", wr_valid, 0);
      chk("rst_wr_rs", wr_rs, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_init_done", init_done, 0);
      @(posedge clk);
      #1;
      exp_q.push_back({1'b0, 8'h38});
      exp_q.push_back({1'b0, 8'h0C});
      exp_q.push_back({1'b0, 8'h06});
      exp_q.push_back({1'b0, 8'h01});
      rst = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge clk);
         if (init_done && exp_q.size() == 0 && done_q.size() == 0 && gnt == 2'b00) break;
      end
      if (i == budget) flag(name);
   endtask

   task automatic wait_gnt(input string name);
      int i;
      for (i = 0; i < 60; i++) begin
         @(negedge clk);
         if (gnt != 2'b00) break;
      end
      if (i == 60) flag(name);
   endtask

   task automatic rand_bufs();
      for (int i = 0; i < 16; i++) begin
         buf0[i] = 8'($urandom_range(32, 126));
         buf1[i] = 8'($urandom_range(32, 126));
      end
   endtask

   task automatic push_xfer(input int who, input logic line);
      exp_q.push_back({1'b0, line ? 8'hC0 : 8'h80});
      for (int i = 0; i < 16; i++)
         exp_q.push_back({1'b1, (who == 1) ? buf1[i] : buf0[i]});
      gnt_q.push_back(2'(1 << who));
      done_q.push_back(2'(1 << who));
      model_last = who;
   endtask

   // One single-requester refresh; req is dropped right after grant.
   task automatic run_xfer(input int who, input logic line);
      push_xfer(who, line);
      @(posedge clk);
      #1 req[who] = 1'b1;
      req_line[who] = line;
      wait_gnt("grant_timeout");
      @(posedge clk);
      #1 req = 2'b00;
      wait_idle("xfer_timeout", 3000);
   endtask

   initial begin
      string s;
      int    base;
      int    k;
      int    who;
      for (int i = 0; i < 16; i++) begin buf0[i] = 8'h20; buf1[i] = 8'h20; end

      // Reset and init sequence.
      do_reset();
      wait_idle("init_timeout", 200);
      chk("init_done_high", init_done, 1);

      // Status line with a fixed text on line 1.
      s = "Temp: 25C Gas:0 ";
      for (int i = 0; i < 16; i++) buf0[i] = s[i];
      run_xfer(0, 1'b0);

      // Random stalls during data.
      rand_ready = 1'b1;
      rand_bufs();
      run_xfer(1, 1'b0);
      rand_bufs();
      run_xfer(0, 1'b1);

      // Line 2 with req dropped after grant.
      rand_ready = 1'b0;
      rand_bufs();
      run_xfer(1, 1'b1);

      // Random mix.
      for (int t = 0; t < 6; t++) begin
         rand_ready = 1'($urandom_range(0, 1));
         rand_bufs();
         run_xfer(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // Reset after the 5th data byte aborts without done.
      rand_ready = 1'b0;
      rand_bufs();
      push_xfer(0, 1'b0);
      base = n_data_hs;
      @(posedge clk);
      #1 req = 2'b01;
      req_line = 2'b00;
      wait_gnt("abort_grant_timeout");
      @(posedge clk);
      #1 req = 2'b00;
      for (k = 0; k < 100; k++) begin
         @(negedge clk);
         if (n_data_hs >= base + 5) break;
      end
      if (k == 100) flag("abort_data_timeout");
      do_reset();
      wait_idle("reinit_timeout", 200);

      // Both requesters held continuously.
      rand_ready = 1'b1;
      rand_bufs();
      req_line = 2'($urandom_range(0, 3));
      for (int t = 0; t < 4; t++) begin
`ifdef LCD_SCHED_ALERT_PRIO_EN
         who = 1;
`else
         who = 1 - model_last;
`endif
         push_xfer(who, req_line[who]);
      end
      base = n_gnts;
      @(posedge clk);
      #1 req = 2'b11;
      for (k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (n_gnts >= base + 4) break;
      end
      if (k == 1000) flag("both_grant_timeout");
      @(posedge clk);
      #1 req = 2'b00;
      wait_idle("both_timeout", 3000);

      repeat (5) @(negedge clk);
      chk("leftover_bytes", exp_q.size(), 0);
      chk("leftover_done", done_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
